// File: rtl/rip_pkg.sv
// Shared types for the RIP ALU sharing logic: instruction flags, ALU request bus
// and port-count limits.
package rip_pkg;

    localparam int RIP_ALU_MAX_PORTS = 4;
    localparam int RIP_ALU_ID_W      = 2;

    typedef struct packed {
        logic is_lui;
        logic is_addi;
        logic is_add;
        logic is_sub;
        logic is_and;
        logic is_or;
        logic is_xor;
        logic is_csrrwi;
    } inst_t;

    typedef struct packed {
        inst_t       inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] csr;
        logic [31:0] imm;
        logic [4:0]  zimm;
    } alu_req_t;

endpackage

// File: rtl/rip_alu_rsp_buf.sv
// One-entry response holding register for a single ALU port: bypasses the live
// ALU result, parks it when the consumer stalls, and drops everything on flush.
module rip_alu_rsp_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        bypass_v,
    input  logic [31:0] rslt,
    input  logic        rsp_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        full
);

    logic        full_r;
    logic [31:0] data_r;
    logic        capture_s;
    logic        full_nxt_s;

    // Park an unconsumed bypass result; a full entry drains on rsp_ready.
    always_comb begin
        capture_s  = bypass_v & ~rsp_ready & ~flush;
        full_nxt_s = 1'b0;
        if (flush) begin
            full_nxt_s = 1'b0;
        end else if (full_r) begin
            full_nxt_s = ~rsp_ready;
        end else begin
            full_nxt_s = capture_s;
        end
    end

    // Holding register and its full flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            data_r <= 32'd0;
        end else begin
            full_r <= full_nxt_s;
            data_r <= capture_s ? rslt : data_r;
        end
    end

    // Buffered data takes precedence; eligibility keeps bypass and buffer exclusive.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = 32'd0;
        if (flush) begin
            rsp_valid = 1'b0;
            rsp_data  = 32'd0;
        end else if (full_r) begin
            rsp_valid = 1'b1;
            rsp_data  = data_r;
        end else if (bypass_v) begin
            rsp_valid = 1'b1;
            rsp_data  = rslt;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'd0;
        end
    end

    assign full = full_r;

endmodule

// File: rtl/rip_alu_arbiter.sv
// Shares one registered ALU between the core (port 0) and coprocessor ports.
// Define RIP_ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module rip_alu_arbiter
    import rip_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_valid,
    output logic [NUM_PORTS-1:0] req_ready,
    input  alu_req_t             req [NUM_PORTS],
    output logic [NUM_PORTS-1:0] rsp_valid,
    input  logic [NUM_PORTS-1:0] rsp_ready,
    output logic [31:0]          rsp_data [NUM_PORTS],
    input  logic                 flush0,
    output alu_req_t             alu_req,
    input  logic [31:0]          alu_rslt
);

    localparam int ID_W = RIP_ALU_ID_W;

    logic                         inflight_v_r;
    logic [ID_W-1:0]              inflight_id_r;
    logic [NUM_PORTS-1:0]         buf_full_s;
    logic [NUM_PORTS-1:0]         bypass_v_s;
    logic [RIP_ALU_MAX_PORTS-1:0] elig_s;
    logic                         gnt_v_s;
    logic [ID_W-1:0]              gnt_id_s;
    logic [ID_W-1:0]              cand_s;
    logic [ID_W-1:0]              start_s;

    // A port whose current result is stalled must not issue again until it drains.
    always_comb begin
        elig_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            elig_s[p] = rst_n & req_valid[p] & ~buf_full_s[p]
                      & ~(bypass_v_s[p] & ~rsp_ready[p])
                      & ~((p == 0) & flush0);
        end
    end

    // Search from start_s; walking backwards lets the nearest eligible port win.
    always_comb begin
        gnt_v_s  = 1'b0;
        gnt_id_s = '0;
        cand_s   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand_s   = ID_W'((int'(start_s) + i) % NUM_PORTS);
            gnt_id_s = elig_s[cand_s] ? cand_s : gnt_id_s;
            gnt_v_s  = gnt_v_s | elig_s[cand_s];
        end
    end

    // One-hot grant and operand bus mux; idle bus is all-zero.
    always_comb begin
        req_ready = '0;
        alu_req   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_ready[p] = gnt_v_s && (gnt_id_s == ID_W'(p));
            alu_req      = req_ready[p] ? req[p] : alu_req;
        end
    end

    // In-flight tracker; the ALU result belongs to last cycle's grantee.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_v_r  <= 1'b0;
            inflight_id_r <= '0;
        end else begin
            inflight_v_r  <= gnt_v_s;
            inflight_id_r <= gnt_v_s ? gnt_id_s : inflight_id_r;
        end
    end

`ifdef RIP_ALU_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr_r;

    // Advance the round-robin pointer past each granted port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (gnt_v_s) begin
            rr_ptr_r <= (gnt_id_s == ID_W'(NUM_PORTS - 1)) ? '0 : gnt_id_s + ID_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign start_s = rr_ptr_r;
`else
    assign start_s = '0;
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign bypass_v_s[p] = inflight_v_r && (inflight_id_r == ID_W'(p));

        rip_alu_rsp_buf u_rsp_buf (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     ((p == 0) ? flush0 : 1'b0),
            .bypass_v  (bypass_v_s[p]),
            .rslt      (alu_rslt),
            .rsp_ready (rsp_ready[p]),
            .rsp_valid (rsp_valid[p]),
            .rsp_data  (rsp_data[p]),
            .full      (buf_full_s[p])
        );
    end

endmodule

// File: tb/tb_rip_alu_arbiter.sv
// Self-checking bench for rip_alu_arbiter: behavioural ALU, per-port result
// scoreboard, and directed scenarios for latency, arbitration, stall, flush, reset.
module tb_rip_alu_arbiter;
    import rip_pkg::*;

    localparam int NUM_PORTS = 2;
    localparam int K_ADDI = 0;
    localparam int K_ADD  = 1;
    localparam int K_SUB  = 2;
    localparam int K_XOR  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_PORTS-1:0] req_valid;
    logic [NUM_PORTS-1:0] req_ready;
    alu_req_t             req [NUM_PORTS];
    logic [NUM_PORTS-1:0] rsp_valid;
    logic [NUM_PORTS-1:0] rsp_ready;
    logic [31:0]          rsp_data [NUM_PORTS];
    logic                 flush0;
    alu_req_t             alu_req;
    logic [31:0]          alu_rslt = 32'd0;

    int ntests = 0;
    int nfail  = 0;
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    rip_alu_arbiter #(.NUM_PORTS(NUM_PORTS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req       (req),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .flush0    (flush0),
        .alu_req   (alu_req),
        .alu_rslt  (alu_rslt)
    );

    function automatic logic [31:0] alu_model(input alu_req_t r);
        logic [31:0] y;
        y = 32'd0;
        if (r.inst.is_addi)      y = r.rs1 + r.imm;
        else if (r.inst.is_add)  y = r.rs1 + r.rs2;
        else if (r.inst.is_sub)  y = r.rs1 - r.rs2;
        else if (r.inst.is_xor)  y = r.rs1 ^ r.rs2;
        else if (r.inst.is_and)  y = r.rs1 & r.rs2;
        else if (r.inst.is_or)   y = r.rs1 | r.rs2;
        else if (r.inst.is_lui)  y = r.imm;
        else if (r.inst.is_csrrwi) y = r.csr;
        return y;
    endfunction

    function automatic alu_req_t mk_op(input int kind, input logic [31:0] a, input logic [31:0] b);
        alu_req_t r;
        r     = '0;
        r.rs1 = a;
        r.pc  = 32'h0000_1000;
        case (kind)
            K_ADDI: begin r.inst.is_addi = 1'b1; r.imm = b; end
            K_ADD:  begin r.inst.is_add  = 1'b1; r.rs2 = b; end
            K_SUB:  begin r.inst.is_sub  = 1'b1; r.rs2 = b; end
            K_XOR:  begin r.inst.is_xor  = 1'b1; r.rs2 = b; end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Registered ALU: result of this cycle's operand bus appears next cycle.
    always @(posedge clk) alu_rslt <= alu_model(alu_req);

    // Scoreboard: push on accepted request, pop on consumed response.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (flush0) exp_q0.delete();
            if (rsp_valid[0] && rsp_ready[0]) begin
                ntests++;
                if (exp_q0.size() == 0) begin
                    nfail++;
                    $display("FAIL sb_port0: got unexpected result %0d, required no response", rsp_data[0]);
                end else begin
                    exp_v = exp_q0.pop_front();
                    if (rsp_data[0] !== exp_v) begin
                        nfail++;
                        $display("FAIL sb_port0: got %0d, required %0d", rsp_data[0], exp_v);
                    end
                end
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                ntests++;
                if (exp_q1.size() == 0) begin
                    nfail++;
                    $display("FAIL sb_port1: got unexpected result %0d, required no response", rsp_data[1]);
                end else begin
                    exp_v = exp_q1.pop_front();
                    if (rsp_data[1] !== exp_v) begin
                        nfail++;
                        $display("FAIL sb_port1: got %0d, required %0d", rsp_data[1], exp_v);
                    end
                end
            end
            if (req_valid[0] && req_ready[0]) exp_q0.push_back(alu_model(req[0]));
            if (req_valid[1] && req_ready[1]) exp_q1.push_back(alu_model(req[1]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "time limit reached");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        flush0    = 1'b0;
        req[0]    = '0;
        req[1]    = '0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req[0]    = mk_op(K_ADDI, 32'd1, 32'd2);
        req[1]    = mk_op(K_SUB, 32'd8, 32'd1);
        rsp_ready = 2'b11;
        flush0    = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        ntests++; if (req_ready !== 2'b00) begin nfail++; $display("FAIL reset_req_ready: got %b, required 00", req_ready); end
        ntests++; if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL reset_rsp_valid: got %b, required 00", rsp_valid); end
        ntests++; if (rsp_data[0] !== 32'd0) begin nfail++; $display("FAIL reset_rsp_data0: got %h, required 0", rsp_data[0]); end
        ntests++; if (rsp_data[1] !== 32'd0) begin nfail++; $display("FAIL reset_rsp_data1: got %h, required 0", rsp_data[1]); end
        ntests++; if (alu_req !== '0) begin nfail++; $display("FAIL reset_alu_req: got %h, required 0", alu_req); end
        req_valid = 2'b00;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        ntests++; if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL idle_rsp_valid: got %b, required 00", rsp_valid); end
    endtask

    task automatic test_addi();
        do_reset();
        next_cycle();
        req_valid = 2'b01;
        req[0]    = mk_op(K_ADDI, 32'd5, 32'd7);
        rsp_ready = 2'b11;
        @(negedge clk);
        ntests++; if (req_ready !== 2'b01) begin nfail++; $display("FAIL addi_grant: got %b, required 01", req_ready); end
        ntests++; if (alu_req !== req[0]) begin nfail++; $display("FAIL addi_bus: got %h, required %h", alu_req, req[0]); end
        ntests++; if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL addi_early_rsp: got %b, required 00", rsp_valid); end
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        ntests++; if (rsp_valid !== 2'b01) begin nfail++; $display("FAIL addi_rsp_valid: got %b, required 01", rsp_valid); end
        ntests++; if (rsp_data[0] !== 32'd12) begin nfail++; $display("FAIL addi_rsp_data: got %0d, required 12", rsp_data[0]); end
        ntests++; if (alu_req !== '0) begin nfail++; $display("FAIL addi_idle_bus: got %h, required 0", alu_req); end
        next_cycle();
        @(negedge clk);
        ntests++; if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL addi_rsp_drop: got %b, required 00", rsp_valid); end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_gnt;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            req_valid = 2'b11;
            req[0]    = mk_op(K_ADD, i, 32'd100);
            req[1]    = mk_op(K_XOR, i + 1, 32'h0000_00F0);
            rsp_ready = 2'b11;
            @(negedge clk);
`ifdef RIP_ALU_ARB_RR_EN
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_gnt = 2'b01;
`endif
            ntests++;
            if (req_ready !== exp_gnt) begin
                nfail++;
                $display("FAIL arb_grant%0d: got %b, required %b", i, req_ready, exp_gnt);
            end
        end
        next_cycle();
        req_valid = 2'b10;
        req[1]    = mk_op(K_XOR, 32'd9, 32'h0000_000F);
        @(negedge clk);
        ntests++; if (req_ready !== 2'b10) begin nfail++; $display("FAIL arb_port1_late: got %b, required 10", req_ready); end
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        ntests++; if (rsp_valid !== 2'b10) begin nfail++; $display("FAIL arb_rsp_valid: got %b, required 10", rsp_valid); end
        ntests++; if (rsp_data[1] !== 32'h0000_0006) begin nfail++; $display("FAIL arb_rsp_data1: got %h, required 6", rsp_data[1]); end
        next_cycle();
    endtask

    task automatic test_stall();
        do_reset();
        next_cycle();
        req_valid = 2'b10;
        req[1]    = mk_op(K_SUB, 32'd10, 32'd3);
        rsp_ready = 2'b01;
        @(negedge clk);
        ntests++; if (req_ready !== 2'b10) begin nfail++; $display("FAIL stall_first_grant: got %b, required 10", req_ready); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            req_valid = 2'b11;
            req[0]    = mk_op(K_ADDI, i, 32'd1);
            req[1]    = mk_op(K_SUB, 32'd20, 32'd5);
            rsp_ready = 2'b01;
            @(negedge clk);
            ntests++; if (req_ready !== 2'b01) begin nfail++; $display("FAIL stall_grant%0d: got %b, required 01", i, req_ready); end
            ntests++; if (rsp_valid[1] !== 1'b1) begin nfail++; $display("FAIL stall_valid%0d: got %b, required 1", i, rsp_valid[1]); end
            ntests++; if (rsp_data[1] !== 32'd7) begin nfail++; $display("FAIL stall_hold%0d: got %0d, required 7", i, rsp_data[1]); end
        end
        next_cycle();
        rsp_ready = 2'b11;
        req[0]    = mk_op(K_ADDI, 32'd3, 32'd1);
        @(negedge clk);
        ntests++; if (req_ready !== 2'b01) begin nfail++; $display("FAIL stall_drain_grant: got %b, required 01", req_ready); end
        ntests++; if (rsp_data[1] !== 32'd7) begin nfail++; $display("FAIL stall_drain_data: got %0d, required 7", rsp_data[1]); end
        next_cycle();
        req_valid = 2'b10;
        @(negedge clk);
        ntests++; if (req_ready !== 2'b10) begin nfail++; $display("FAIL stall_regrant: got %b, required 10", req_ready); end
        ntests++; if (rsp_valid !== 2'b01) begin nfail++; $display("FAIL stall_after_drain_valid: got %b, required 01", rsp_valid); end
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        ntests++; if (rsp_valid !== 2'b10) begin nfail++; $display("FAIL stall_second_valid: got %b, required 10", rsp_valid); end
        ntests++; if (rsp_data[1] !== 32'd15) begin nfail++; $display("FAIL stall_second_data: got %0d, required 15", rsp_data[1]); end
        next_cycle();
    endtask

    task automatic test_flush();
        do_reset();
        next_cycle();
        req_valid = 2'b01;
        req[0]    = mk_op(K_ADDI, 32'd1, 32'd2);
        rsp_ready = 2'b11;
        @(negedge clk);
        ntests++; if (req_ready !== 2'b01) begin nfail++; $display("FAIL flush_grant0: got %b, required 01", req_ready); end
        next_cycle();
        flush0    = 1'b1;
        req_valid = 2'b11;
        req[0]    = mk_op(K_ADDI, 32'd40, 32'd2);
        req[1]    = mk_op(K_SUB, 32'd9, 32'd4);
        rsp_ready = 2'b10;
        @(negedge clk);
        ntests++; if (req_ready !== 2'b10) begin nfail++; $display("FAIL flush_grant1: got %b, required 10", req_ready); end
        ntests++; if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL flush_mask: got %b, required 00", rsp_valid); end
        next_cycle();
        flush0    = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        ntests++; if (rsp_valid !== 2'b10) begin nfail++; $display("FAIL flush_port1_valid: got %b, required 10", rsp_valid); end
        ntests++; if (rsp_data[1] !== 32'd5) begin nfail++; $display("FAIL flush_port1_data: got %0d, required 5", rsp_data[1]); end
        next_cycle();
        @(negedge clk);
        ntests++; if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL flush_no_stale: got %b, required 00", rsp_valid); end
        next_cycle();
        flush0    = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        ntests++; if (req_ready !== 2'b00) begin nfail++; $display("FAIL flush_ready_mask: got %b, required 00", req_ready); end
        next_cycle();
        flush0    = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        ntests++; if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL flush_idle: got %b, required 00", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        next_cycle();
        req_valid = 2'b10;
        req[1]    = mk_op(K_SUB, 32'd10, 32'd3);
        rsp_ready = 2'b00;
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
        @(negedge clk);
        ntests++; if (rsp_data[1] !== 32'd7) begin nfail++; $display("FAIL rmid_buffered: got %0d, required 7", rsp_data[1]); end
        next_cycle();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req[0]    = mk_op(K_ADDI, 32'd5, 32'd7);
        @(negedge clk);
        ntests++; if (req_ready !== 2'b00) begin nfail++; $display("FAIL rmid_ready_in_reset: got %b, required 00", req_ready); end
        next_cycle();
        rst_n     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        ntests++; if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL rmid_rsp_valid: got %b, required 00", rsp_valid); end
        ntests++; if (rsp_data[1] !== 32'd0) begin nfail++; $display("FAIL rmid_rsp_data1: got %0d, required 0", rsp_data[1]); end
        ntests++; if (req_ready !== 2'b00) begin nfail++; $display("FAIL rmid_req_ready: got %b, required 00", req_ready); end
        ntests++; if (alu_req !== '0) begin nfail++; $display("FAIL rmid_alu_req: got %h, required 0", alu_req); end
        next_cycle();
        req_valid = 2'b11;
        @(negedge clk);
        ntests++; if (req_ready !== 2'b01) begin nfail++; $display("FAIL rmid_cold_grant: got %b, required 01", req_ready); end
        next_cycle();
        req_valid = 2'b10;
        @(negedge clk);
        ntests++; if (rsp_data[0] !== 32'd12) begin nfail++; $display("FAIL rmid_cold_data: got %0d, required 12", rsp_data[0]); end
        ntests++; if (req_ready !== 2'b10) begin nfail++; $display("FAIL rmid_port1_grant: got %b, required 10", req_ready); end
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        ntests++; if (rsp_data[1] !== 32'd7) begin nfail++; $display("FAIL rmid_port1_data: got %0d, required 7", rsp_data[1]); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_arbitration();
        test_stall();
        test_flush();
        test_reset_mid();
        next_cycle();
        ntests++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            nfail++;
            $display("FAIL sb_drain: got %0d/%0d pending results, required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
